// File: rtl/relu_requant_3_pkg.sv
// Shared sizing and state encoding for the layer-3 activation/requantisation stage.
package nn_parameters;

  localparam int OUT_SIZE_3 = 32;
  localparam int L3_ACC_W   = 56;
  localparam int L4_IN_W    = 40;
  localparam int L3_SHIFT   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } rq_state_t;

endpackage

// File: rtl/relu_requant_3_unit.sv
// One element of ReLU + round-half-up arithmetic shift + positive saturation.
module relu_requant_unit #(
  parameter int IN_W  = 56,
  parameter int OUT_W = 40,
  parameter int SHIFT = 16
) (
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] r,
  output logic             sat
);

  localparam int                     RSH    = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [IN_W:0]   RND    = (SHIFT > 0) ? ((IN_W + 1)'(1) << RSH) : '0;
  localparam logic [OUT_W-1:0]       OUTMAX = {1'b0, {(OUT_W - 1){1'b1}}};

  logic signed [IN_W:0] xe;
  logic signed [IN_W:0] sum;
  logic signed [IN_W:0] shifted;
  logic                 positive;

  // One extra bit of headroom so adding the rounding constant cannot wrap.
  assign xe       = {x[IN_W-1], x};
  assign sum      = xe + RND;
  assign shifted  = sum >>> SHIFT;
  assign positive = !x[IN_W-1] && (|x);

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    r   = '0;
    sat = 1'b0;
    if (positive) begin
      if (|shifted[IN_W:OUT_W-1]) begin
        r   = OUTMAX;
        sat = 1'b1;
      end else begin
        r = shifted[OUT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/relu_requant_3.sv
// Vector-in / vector-out requantiser: buffers a whole accumulator vector and
// converts it one element per cycle into a held output register bank.
module relu_requant_3
  import nn_parameters::*;
#(
  parameter int N     = OUT_SIZE_3,
  parameter int IN_W  = L3_ACC_W,
  parameter int OUT_W = L4_IN_W,
  parameter int SHIFT = L3_SHIFT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*IN_W-1:0]    in_vector,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*OUT_W-1:0]   out_vector,
  output logic                 sat_flag
);

  localparam int               IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);

  rq_state_t                   state;
  logic [IDX_W-1:0]            idx;
  logic [N-1:0][IN_W-1:0]      in_buf;
  logic [N-1:0][OUT_W-1:0]     out_bank;
  logic [OUT_W-1:0]            elem_r;
  logic                        elem_sat;
  logic                        accept;

  assign in_ready   = (state == IDLE);
  assign accept     = in_valid && in_ready && rst;
  assign out_vector = out_bank;

  relu_requant_unit #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_unit (
    .x   (in_buf[idx]),
    .r   (elem_r),
    .sat (elem_sat)
  );

  // NOTE: the input buffer is plain storage with no reset; only the state,
  // index and the visible output bank need a defined value after reset.
  always_ff @(posedge clk) begin
    if (accept) in_buf <= in_vector;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_bank  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            idx      <= '0;
            sat_flag <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          out_bank[idx] <= elem_r;
          sat_flag      <= sat_flag | elem_sat;
          idx           <= idx + 1'b1;
          if (idx == LAST) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_requant_3.sv
// Directed, table-driven bench for relu_requant_3 (N=32, SHIFT=16, OUT_W=40).
module tb_relu_requant_3;

  localparam int N     = 32;
  localparam int IN_W  = 56;
  localparam int OUT_W = 40;

  typedef struct {
    logic [IN_W-1:0]  x;
    logic [OUT_W-1:0] r;
    logic             sat;
  } elem_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [N-1:0][IN_W-1:0]  in_vector;
  logic                    out_valid;
  logic                    out_ready;
  logic [N-1:0][OUT_W-1:0] out_vector;
  logic                    sat_flag;

  elem_t                   tbl [13];
  logic [N-1:0][IN_W-1:0]  v;
  logic [N-1:0][OUT_W-1:0] exp_v;
  logic                    exp_sat;
  int                      total = 0;
  int                      bad   = 0;

  relu_requant_3 dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vector  (in_vector),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vector (out_vector),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // kind 0: table entries 0..10 then i<<16; kind 1: saturating entries at 5 and 20;
  // kind 2: table entries reversed then (i<<16)+0x8000, which rounds up to i+1.
  task automatic build(input int kind);
    for (int i = 0; i < N; i++) begin
      if (kind == 0 && i < 11) begin
        v[i] = tbl[i].x;
        exp_v[i] = tbl[i].r;
      end else if (kind == 2 && i < 11) begin
        v[i] = tbl[10-i].x;
        exp_v[i] = tbl[10-i].r;
      end else if (kind == 2) begin
        v[i] = (IN_W'(i) << 16) | IN_W'(32'h8000);
        exp_v[i] = OUT_W'(i + 1);
      end else begin
        v[i] = IN_W'(i) << 16;
        exp_v[i] = OUT_W'(i);
      end
    end
    if (kind == 1) begin
      v[5]      = tbl[11].x;
      exp_v[5]  = tbl[11].r;
      v[20]     = tbl[12].x;
      exp_v[20] = tbl[12].r;
    end
    exp_sat = (kind == 1);
  endtask

  task automatic send_and_wait(input string tag);
    int   cycles;
    logic ir_seen;
    @(negedge clk);
    in_vector = v;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cycles   = 0;
    ir_seen  = 1'b0;
    while (!out_valid && cycles < 100) begin
      if (in_ready) ir_seen = 1'b1;
      @(posedge clk);
      #1;
      cycles++;
    end
    check({tag, "_latency"}, 64'(cycles), 64'd32);
    check({tag, "_in_ready_run"}, 64'(ir_seen), 64'd0);
  endtask

  task automatic check_out(input string tag);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_elem%0d", tag, i), 64'(out_vector[i]), 64'(exp_v[i]));
    check({tag, "_sat"}, 64'(sat_flag), 64'(exp_sat));
    check({tag, "_in_ready_hold"}, 64'(in_ready), 64'd0);
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    tbl[0]  = '{56'h30000,            40'd3,             1'b0};
    tbl[1]  = '{56'h18000,            40'd2,             1'b0};
    tbl[2]  = '{56'h17FFF,            40'd1,             1'b0};
    tbl[3]  = '{56'hFFFFFFFFFFFFFB,   40'd0,             1'b0};
    tbl[4]  = '{56'h0,                40'd0,             1'b0};
    tbl[5]  = '{56'h1,                40'd0,             1'b0};
    tbl[6]  = '{56'h7FFF,             40'd0,             1'b0};
    tbl[7]  = '{56'h8000,             40'd1,             1'b0};
    tbl[8]  = '{56'h80000000000000,   40'd0,             1'b0};
    tbl[9]  = '{56'h7FFFFFFFFF0000,   40'h7FFFFFFFFF,    1'b0};
    tbl[10] = '{56'h7FFFFFFFFF7FFF,   40'h7FFFFFFFFF,    1'b0};
    tbl[11] = '{56'h7FFFFFFFFFFFFF,   40'h7FFFFFFFFF,    1'b1};
    tbl[12] = '{56'h7FFFFFFFFF8000,   40'h7FFFFFFFFF,    1'b1};

    rst       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_vector = '1;

    // Reset held for three edges with in_valid asserted.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sat", 64'(sat_flag), 64'd0);
    check("rst_vec_zero", 64'(out_vector == '0), 64'd1);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_no_accept", 64'(out_valid), 64'd0);

    // Non-saturating table vector, with latency and in_ready checked.
    build(0);
    send_and_wait("vecA");
    check_out("vecA");
    release_out("vecA");

    // Saturating vector, held in HOLD for 10 cycles while upstream toggles.
    build(1);
    send_and_wait("vecB");
    check_out("vecB");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid  = ~in_valid;
      in_vector = {N{IN_W'({$urandom, $urandom})}};
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_vec", c), 64'(out_vector === exp_v), 64'd1);
      check($sformatf("hold%0d_sat", c), 64'(sat_flag), 64'd1);
      check($sformatf("hold%0d_valid", c), 64'(out_valid), 64'd1);
      check($sformatf("hold%0d_in_ready", c), 64'(in_ready), 64'd0);
    end
    release_out("vecB");

    // Back-to-back: next vector right after release, sat must clear.
    build(2);
    send_and_wait("vecC");
    check_out("vecC");
    release_out("vecC");

    // Reset in the middle of RUN once idx has reached 10.
    build(0);
    @(negedge clk);
    in_vector = v;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_vec_zero", 64'(out_vector == '0), 64'd1);
    check("midrst_sat", 64'(sat_flag), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;

    build(2);
    send_and_wait("vecD");
    check_out("vecD");
    release_out("vecD");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
